// File: rtl/ecc_apb_host.sv
// APB initiator for the ECC core: one command -> four register writes (CTRL last),
// wait for operation_done, return captured result. Optional WAIT_DONE timeout: ECC_APB_HOST_TIMEOUT_EN.
module ecc_apb_host #(
    parameter int DATA_WIDTH      = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [1:0]                 cmd_width,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_num_errors,
    output logic [1:0]                 rsp_status,
    output logic                       busy,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    input  logic                       operation_done,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic [1:0]                 num_of_errors
);

    if (DATA_WIDTH > AMBA_WORD || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ecc_apb_host: DATA_WIDTH must be <= AMBA_WORD and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT_DONE, RESP} state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD_OP  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    state_t                       state, state_n;
    logic [1:0]                   idx, idx_n;
    logic [1:0]                   op_q, width_q;
    logic [DATA_WIDTH-1:0]        noise_q;
    logic                         accept;

    logic                         psel_n, penable_n, pwrite_n;
    logic [AMBA_ADDR_WIDTH-1:0]   paddr_n;
    logic [AMBA_WORD-1:0]         pwdata_n;
    logic                         rsp_valid_n;
    logic [DATA_WIDTH-1:0]        rsp_data_n;
    logic [1:0]                   rsp_num_errors_n, rsp_status_n;

    logic [1:0]                   wr_idx;
    logic [AMBA_ADDR_WIDTH-1:0]   wr_addr;
    logic [AMBA_WORD-1:0]         wr_word;

`ifdef ECC_APB_HOST_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt, tmo_cnt_n;
`endif

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // Slot 0 (DATA_IN) is only ever issued from IDLE, so it comes straight off cmd_data;
    // the later slots use the copies latched at accept.
    always_comb begin
        wr_idx = (state == IDLE) ? 2'd0 : idx + 2'd1;
        case (wr_idx)
            2'd0:    begin wr_addr = AMBA_ADDR_WIDTH'(4'h4); wr_word = AMBA_WORD'(cmd_data); end
            2'd1:    begin wr_addr = AMBA_ADDR_WIDTH'(4'h8); wr_word = AMBA_WORD'(width_q);  end
            2'd2:    begin wr_addr = AMBA_ADDR_WIDTH'(4'hC); wr_word = AMBA_WORD'(noise_q);  end
            default: begin wr_addr = AMBA_ADDR_WIDTH'(4'h0); wr_word = AMBA_WORD'(op_q);     end
        endcase
    end

    always_comb begin
        state_n          = state;
        idx_n            = idx;
        psel_n           = PSEL;
        penable_n        = PENABLE;
        pwrite_n         = PWRITE;
        paddr_n          = PADDR;
        pwdata_n         = PWDATA;
        rsp_valid_n      = rsp_valid;
        rsp_data_n       = rsp_data;
        rsp_num_errors_n = rsp_num_errors;
        rsp_status_n     = rsp_status;
`ifdef ECC_APB_HOST_TIMEOUT_EN
        tmo_cnt_n        = tmo_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == 2'b11) begin
                        state_n          = RESP;
                        rsp_valid_n      = 1'b1;
                        rsp_status_n     = ST_BAD_OP;
                        rsp_data_n       = '0;
                        rsp_num_errors_n = '0;
                    end else begin
                        state_n   = SETUP;
                        idx_n     = 2'd0;
                        psel_n    = 1'b1;
                        penable_n = 1'b0;
                        pwrite_n  = 1'b1;
                        paddr_n   = wr_addr;
                        pwdata_n  = wr_word;
                    end
                end
            end
            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end
            ACCESS: begin
                penable_n = 1'b0;
                if (idx != 2'd3) begin
                    state_n  = SETUP;
                    idx_n    = idx + 2'd1;
                    paddr_n  = wr_addr;
                    pwdata_n = wr_word;
                end else begin
                    state_n = WAIT_DONE;
                    psel_n  = 1'b0;
`ifdef ECC_APB_HOST_TIMEOUT_EN
                    tmo_cnt_n = '0;
`endif
                end
            end
            WAIT_DONE: begin
                // A done pulse in the same cycle as the limit still counts as success.
                if (operation_done) begin
                    state_n          = RESP;
                    rsp_valid_n      = 1'b1;
                    rsp_status_n     = ST_OK;
                    rsp_data_n       = data_out;
                    rsp_num_errors_n = num_of_errors;
                end
`ifdef ECC_APB_HOST_TIMEOUT_EN
                else if (tmo_cnt == TMO_LAST) begin
                    state_n          = RESP;
                    rsp_valid_n      = 1'b1;
                    rsp_status_n     = ST_TIMEOUT;
                    rsp_data_n       = '0;
                    rsp_num_errors_n = '0;
                end else begin
                    tmo_cnt_n = tmo_cnt + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n     = IDLE;
                    rsp_valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            op_q           <= '0;
            width_q        <= '0;
            noise_q        <= '0;
            PSEL           <= 1'b0;
            PENABLE        <= 1'b0;
            PWRITE         <= 1'b0;
            PADDR          <= '0;
            PWDATA         <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_num_errors <= '0;
            rsp_status     <= '0;
`ifdef ECC_APB_HOST_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            state          <= state_n;
            idx            <= idx_n;
            PSEL           <= psel_n;
            PENABLE        <= penable_n;
            PWRITE         <= pwrite_n;
            PADDR          <= paddr_n;
            PWDATA         <= pwdata_n;
            rsp_valid      <= rsp_valid_n;
            rsp_data       <= rsp_data_n;
            rsp_num_errors <= rsp_num_errors_n;
            rsp_status     <= rsp_status_n;
`ifdef ECC_APB_HOST_TIMEOUT_EN
            tmo_cnt        <= tmo_cnt_n;
`endif
            if (accept) begin
                op_q    <= cmd_op;
                width_q <= cmd_width;
                noise_q <= cmd_noise;
            end
        end
    end

endmodule

// File: doc/ecc_apb_host.md
Name: ecc_apb_host

Overview:
- APB initiator that drives the ECC encoder/decoder core through its APB slave port.
- Accepts one command per valid/ready handshake and issues the register write sequence. It then waits for operation_done, captures data_out and num_of_errors, and returns a response via valid/ready.
- Sits between system firmware/test logic and the ECC core; it is the requester side of the core's register interface.

Parameters:
- DATA_WIDTH, 32, width of the data_out bus and of the cmd_data/cmd_noise payloads (must be ≤ AMBA_WORD).
- AMBA_ADDR_WIDTH, 20, PADDR width.
- AMBA_WORD, 32, PWDATA width.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT_DONE (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 encode, 01 decode, 10 full channel, 11 invalid.
- cmd_width  in  2  codeword width code (00 8b, 01 16b, 10 32b).
- cmd_data  in  DATA_WIDTH  DATA_IN payload.
- cmd_noise  in  DATA_WIDTH  NOISE payload.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  captured data_out.
- rsp_num_errors  out  2  captured num_of_errors.
- rsp_status  out  2  00 ok, 01 invalid op, 10 timeout.
- busy  out  1  high in any state other than IDLE.
- PADDR  out  AMBA_ADDR_WIDTH  APB address.
- PWDATA  out  AMBA_WORD  APB write data.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write.
- operation_done  in  1  core completion pulse.
- data_out  in  DATA_WIDTH  core result.
- num_of_errors  in  2  core error count.

Behaviour:
- Register map (byte addresses, upper PADDR bits 0):
  - CTRL 0x00
  - DATA_IN 0x04
  - CODEWORD_WIDTH 0x08
  - NOISE 0x0C
- Write order per command: DATA_IN, CODEWORD_WIDTH, NOISE, CTRL.
  - CTRL is always written last because a CTRL write starts the core.
  - PWDATA is zero-extended: cmd_data, {30'b0,cmd_width}, cmd_noise, {30'b0,cmd_op}.
- Command latching: cmd_op/width/data/noise are latched on the accepting edge (cmd_valid & cmd_ready). Later input changes are ignored until the next accept.
- States:
  - IDLE: cmd_ready=1. On accept, go to SETUP with write index 0. If cmd_op==11, go to RESP with rsp_status=01 and issue no APB traffic.
  - SETUP: PSEL=1, PENABLE=0, PWRITE=1, PADDR/PWDATA valid. Next state ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, same address and data. Transfer completes in this cycle (no PREADY). If index<3, increment the index and go to SETUP; else go to WAIT_DONE.
  - WAIT_DONE: PSEL=PENABLE=0. On operation_done=1, capture data_out and num_of_errors into rsp_*, set rsp_status=00, go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE; a new command can be accepted the cycle after.
- Timing: SETUP/ACCESS alternate with no idle cycles between writes, so the 4 writes take 8 cycles. Minimum accept-to-rsp_valid latency is 10 cycles (8 write cycles, at least 1 WAIT_DONE cycle, then RESP).
- operation_done outside WAIT_DONE is ignored; this includes a pulse coincident with the CTRL ACCESS cycle.
- APB outputs are registered. PSEL and PENABLE are never high outside SETUP/ACCESS. PADDR, PWDATA and PWRITE hold their last values when idle.
- Reset values (all outputs):
  - state IDLE, cmd_ready=1, busy=0
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0
  - rsp_valid=0, rsp_data=0, rsp_num_errors=0, rsp_status=0
- Reset mid-transfer: asynchronously returns to IDLE and drops PSEL/PENABLE immediately. The in-flight command is lost and no response is produced.
- Back-pressure: while rsp_valid=1 and rsp_ready=0, rsp_* are stable and cmd_ready=0.

Optional Feature:
- Macro: ECC_APB_HOST_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter (width = clog2(TIMEOUT_CYCLES+1)) clears on entry to WAIT_DONE and increments each cycle there.
  - When the count reaches TIMEOUT_CYCLES without operation_done, go to RESP with rsp_status=10, rsp_data=0, rsp_num_errors=0.
  - If operation_done arrives in the same cycle the limit is reached, operation_done wins and rsp_status=00.
- Undefined: no counter exists; WAIT_DONE waits indefinitely, and status 10 is never produced.

Test Plan:
- Encode: cmd_op=00, width=00, data=0x5. Required APB sequence: 0x04←0x5, 0x08←0x0, 0x0C←noise, 0x00←0x0. Then core pulses operation_done with data_out=0xA5 → rsp_valid=1, rsp_data=0xA5, status 00, first rsp_valid 10 cycles after accept.
- Full channel: op=10, width=01, noise=0x0004, core returns num_of_errors=01 → rsp_num_errors=01, rsp_status=00. The CTRL write carries PWDATA=0x2.
- Invalid op: op=11 → no PSEL assertion at all; rsp_valid the cycle after accept with rsp_status=01.
- Back-pressure: hold rsp_ready=0 for 5 cycles → rsp_* stable and cmd_ready=0 throughout. Assert rsp_ready → IDLE next cycle, and a second command is accepted the cycle after.
- Reset: assert rst low during the ACCESS of the NOISE write → PSEL=PENABLE=0 immediately and all outputs at reset values. After release, a fresh encode completes normally.
- Timeout (macro defined, TIMEOUT_CYCLES=16): core never pulses → rsp_status=10 exactly 16 cycles after WAIT_DONE entry. A second run with the pulse on cycle 16 → status 00.
